// File: rtl/sw_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sw_button_ctrl
// Description : Stopwatch button front end: sync, debounce and edge-detect the
//               start/pause and clear buttons, then drive the run-control FSM.
// Revision    : 1.0
// ============================================================================
module sw_button_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic       run,
    output logic       paused,
    output logic       clr_pulse,
    output logic [1:0] state
);

    localparam int c_DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int c_LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_LONG_W-1:0] c_HOLD_MAX = c_LONG_W'(LONG_CYCLES - 1);
    localparam logic [c_LONG_W-1:0] c_HOLD_PRE = c_LONG_W'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_rise;
    logic       w_db_start;
    logic       w_start_rise;
    logic       w_clear_rise;

    assign w_raw = {btn_clear, btn_start};

    // Index 0 is start/pause, index 1 is clear.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic               r_sync1;
            logic               r_sync2;
            logic               r_db;
            logic               r_db_d;
            logic [c_DEB_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_db_d  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    r_db_d  <= r_db;
                    // Any agreeing sample restarts the stability window.
                    if (r_sync2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_db  <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_rise[gi] = r_db & ~r_db_d;
        end
    endgenerate

    assign w_db_start   = g_btn[0].r_db;
    assign w_start_rise = w_rise[0];
    assign w_clear_rise = w_rise[1];

    logic [c_LONG_W-1:0] r_hold;
    logic                r_long_ev;

    // Saturating hold timer; the event fires once, on the step into saturation.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hold    <= '0;
            r_long_ev <= 1'b0;
        end else begin
            r_long_ev <= w_db_start && (r_hold == c_HOLD_PRE);
            if (!w_db_start) begin
                r_hold <= '0;
            end else if (r_hold != c_HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    state_t r_state;
    state_t w_state_nxt;
    logic   w_pulse_nxt;
    logic   r_run;
    logic   r_paused;
    logic   r_clr_pulse;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_run       <= 1'b0;
            r_paused    <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= (w_state_nxt == ST_RUNNING);
            r_paused    <= (w_state_nxt == ST_PAUSED);
            r_clr_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = 1'b0;
        if (w_clear_rise || r_long_ev) begin
            w_state_nxt = ST_IDLE;
            w_pulse_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_start_rise) w_state_nxt = ST_RUNNING;
                ST_RUNNING: if (w_start_rise) w_state_nxt = ST_PAUSED;
                ST_PAUSED:  if (w_start_rise) w_state_nxt = ST_RUNNING;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign run       = r_run;
    assign paused    = r_paused;
    assign clr_pulse = r_clr_pulse;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sw_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_button_ctrl
// Description : Directed and random button stimulus against a window-based
//               reference model of the stopwatch button front end.
// Revision    : 1.0
// ============================================================================
module tb_sw_button_ctrl;

    localparam int DEB  = 4;
    localparam int LNG  = 20;
    localparam int MAXE = 8192;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn_start;
    logic       btn_clear;
    logic       run;
    logic       paused;
    logic       clr_pulse;
    logic [1:0] state;

    sw_button_ctrl #(
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LNG)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .run       (run),
        .paused    (paused),
        .clr_pulse (clr_pulse),
        .state     (state)
    );

    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    string phase       = "init";

    // Model history, indexed by clock edge since the last reset release.
    // m_raw[b][k] = button level before edge k, m_db[b][k] = debounced level after edge k.
    bit m_raw [0:1][0:MAXE-1];
    bit m_db  [0:1][0:MAXE-1];
    int n_edge;
    int m_st;
    bit m_pulse;

    function automatic bit raw_at(int b, int k);
        return (k >= 1 && k <= n_edge) ? m_raw[b][k] : 1'b0;
    endfunction

    function automatic bit db_at(int b, int k);
        return (k >= 1 && k <= n_edge) ? m_db[b][k] : 1'b0;
    endfunction

    task automatic model_reset();
        n_edge  = 0;
        m_st    = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit c);
        bit prev, flip, rise_s, rise_c, long_ev;
        int run_len, j;
        n_edge++;
        if (n_edge >= MAXE) begin
            $display("FAIL model_history observed %0d edges, limit %0d", n_edge, MAXE);
            $fatal(1);
        end
        m_raw[0][n_edge] = s;
        m_raw[1][n_edge] = c;
        // A level is accepted once it has been seen (two edges late) for DEB edges in a row.
        for (int b = 0; b < 2; b++) begin
            prev = db_at(b, n_edge - 1);
            flip = 1'b1;
            for (int k = n_edge - DEB - 1; k <= n_edge - 2; k++)
                if (raw_at(b, k) == prev) flip = 1'b0;
            m_db[b][n_edge] = flip ? ~prev : prev;
        end
        rise_s = db_at(0, n_edge - 1) & ~db_at(0, n_edge - 2);
        rise_c = db_at(1, n_edge - 1) & ~db_at(1, n_edge - 2);
        run_len = 0;
        j = n_edge - 2;
        while (j >= 1 && db_at(0, j)) begin
            run_len++;
            j--;
        end
        long_ev = (run_len == LNG - 1);
        if (rise_c || long_ev) begin
            m_st    = 0;
            m_pulse = 1'b1;
        end else begin
            m_pulse = 1'b0;
            if (rise_s) m_st = (m_st == 1) ? 2 : 1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("state",     state,             2'(m_st));
        chk("run",       {1'b0, run},       (m_st == 1) ? 2'd1 : 2'd0);
        chk("paused",    {1'b0, paused},    (m_st == 2) ? 2'd1 : 2'd0);
        chk("clr_pulse", {1'b0, clr_pulse}, {1'b0, m_pulse});
    endtask

    task automatic cyc(input bit s, input bit c, input bit r);
        @(negedge clk);
        btn_start = s;
        btn_clear = c;
        clr       = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(s, c);
        #1;
        check_outputs();
    endtask

    task automatic release_buttons();
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit   rs, rc, rr;
        int   len;
        logic [1:0] exp_after [0:2];
        exp_after[0] = 2'd1;
        exp_after[1] = 2'd2;
        exp_after[2] = 2'd1;

        clr = 1'b1; btn_start = 1'b0; btn_clear = 1'b0;
        model_reset();
        phase = "reset";
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        phase = "press";
        for (int p = 0; p < 3; p++) begin
            for (int i = 1; i <= 12; i++) begin
                cyc(1'b1, 1'b0, 1'b0);
                if (i == 6) chk("before_edge7", state, (p == 0) ? 2'd0 : exp_after[p-1]);
                if (i == 7) chk("at_edge7", state, exp_after[p]);
            end
            release_buttons();
            chk("after_release", state, exp_after[p]);
        end

        phase = "clear";
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (i == 7) chk("pulse_on", {1'b0, clr_pulse}, 2'd1);
            if (i == 8) chk("pulse_off", {1'b0, clr_pulse}, 2'd0);
        end
        release_buttons();
        chk("idle_after_clear", state, 2'd0);

        phase = "bounce";
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0);
        end
        chk("bounce_rejected", state, 2'd0);
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 6) chk("stable_edge6", state, 2'd0);
            if (i == 7) chk("stable_edge7", state, 2'd1);
        end
        release_buttons();

        phase = "simultaneous";
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
        release_buttons();
        chk("paused_first", state, 2'd2);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            if (i == 7) chk("both_pulse", {clr_pulse, run}, 2'b10);
        end
        release_buttons();
        chk("both_idle", state, 2'd0);

        phase = "long_hold";
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 7)  chk("hold_run", state, 2'd1);
            if (i == 26) chk("hold_clear", {clr_pulse, 1'b0}, 2'b10);
            if (i == 27) chk("hold_single", {clr_pulse, 1'b0}, 2'b00);
        end
        release_buttons();
        chk("hold_release", state, 2'd0);

        phase = "async_clr";
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0);
        release_buttons();
        chk("running_before_clr", state, 2'd1);
        #2;
        clr = 1'b1;
        #1;
        model_reset();
        check_outputs();
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);

        phase = "held_through_clr";
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 6) chk("fresh_edge6", state, 2'd0);
            if (i == 7) chk("fresh_edge7", state, 2'd1);
        end
        release_buttons();

        phase = "random";
        for (int seg = 0; seg < 70; seg++) begin
            rs  = 1'($urandom_range(0, 1));
            rc  = ($urandom_range(0, 4) == 0);
            rr  = ($urandom_range(0, 14) == 0);
            len = $urandom_range(1, 26);
            for (int i = 0; i < len; i++)
                cyc(rs ^ ($urandom_range(0, 7) == 0), rc ^ ($urandom_range(0, 9) == 0), rr && (i < 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
